// File: rtl/truth_table_capture_pkg.sv
// Shared types and helpers for the truth-table capture block.
package truth_table_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Reference table for s = a | (b & ~c), bit i = output at input index i.
    localparam logic [7:0] EXPECTED_A_OR_B_ANDN_C = 8'hF4;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/truth_table_capture_settle_timer.sv
// Reloadable down-counter: ticks once every RELOAD+1 enabled cycles after a load.
module settle_timer
    import truth_table_capture_pkg::*;
#(
    parameter int RELOAD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int CW = width_for(RELOAD);
    localparam logic [CW-1:0] RELOAD_V = CW'(RELOAD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (load) begin
            cnt_d = RELOAD_V;
        end else if (en) begin
            if (cnt_q == '0) begin
                tick  = 1'b1;
                cnt_d = RELOAD_V;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all input vectors of a small combinational function, captures its
// truth table and compares it against an expected minterm mask.
module truth_table_capture
    import truth_table_capture_pkg::*;
#(
    parameter int                   N_IN     = 3,
    parameter int                   SETTLE   = 1,
    parameter logic [2**N_IN-1:0]   EXPECTED = EXPECTED_A_OR_B_ANDN_C
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_tbl,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_mismatch
);

    localparam int TW = 2**N_IN;
    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   MM_ONE   = (N_IN+1)'(1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [TW-1:0]     tbl_q, tbl_d;
    logic [N_IN:0]     mm_cnt_q, mm_cnt_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              pass_q, pass_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tick;

    settle_timer #(.RELOAD(SETTLE)) u_settle (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tbl_d    = tbl_q;
        mm_cnt_d = mm_cnt_q;
        first_d  = first_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    tbl_d    = '0;
                    mm_cnt_d = '0;
                    first_d  = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                tmr_en = 1'b1;
                if (tick) begin
                    tbl_d[idx_q] = dut_out;
                    if (dut_out != EXPECTED[idx_q]) begin
                        mm_cnt_d = mm_cnt_q + MM_ONE;
                        // A zero running count means this is the first miss.
                        if (mm_cnt_q == '0) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        pass_d  = (mm_cnt_d == '0);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            tbl_q    <= '0;
            mm_cnt_q <= '0;
            first_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tbl_q    <= tbl_d;
            mm_cnt_q <= mm_cnt_d;
            first_q  <= first_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in         = (state_q == ST_DRIVE) ? idx_q : '0;
    assign busy           = (state_q == ST_DRIVE);
    assign done           = (state_q == ST_DONE);
    assign truth_tbl      = tbl_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_mismatch = first_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench: stimulus queues expected sweep results, monitors check on done.
module tb_truth_table_capture;

    typedef struct {
        logic [7:0] tbl;
        logic       pss;
        logic [3:0] mm;
        logic [2:0] first;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_a, start_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] tbl_a, tbl_b;
    logic [3:0] mm_a, mm_b;
    logic [2:0] first_a, first_b;
    logic       d1, d2;
    int         mode;
    int         cyc;
    int         checks;
    int         errors;
    exp_t       q_a[$];
    exp_t       q_b[$];

    function automatic logic fn(input int m, input logic [2:0] v);
        case (m)
            0:       return v[2] | (v[1] & ~v[0]);
            1:       return v[2] | v[1];
            default: return 1'b0;
        endcase
    endfunction

    truth_table_capture u_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .truth_tbl(tbl_a), .pass(pass_a),
        .mismatch_cnt(mm_a), .first_mismatch(first_a)
    );

    truth_table_capture #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hF4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .truth_tbl(tbl_b), .pass(pass_b),
        .mismatch_cnt(mm_b), .first_mismatch(first_b)
    );

    assign dut_out_a = fn(mode, dut_in_a);
    assign dut_out_b = d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= fn(0, dut_in_b);
        d2  <= d1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s", name);
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) begin
                fail_now("a_unexpected_done");
            end else begin
                e = q_a.pop_front();
                chk("a_table", 32'(tbl_a), 32'(e.tbl));
                chk("a_pass", 32'(pass_a), 32'(e.pss));
                chk("a_mismatch_cnt", 32'(mm_a), 32'(e.mm));
                chk("a_first_mismatch", 32'(first_a), 32'(e.first));
                chk("a_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_b) begin
            if (q_b.size() == 0) begin
                fail_now("b_unexpected_done");
            end else begin
                e = q_b.pop_front();
                chk("b_table", 32'(tbl_b), 32'(e.tbl));
                chk("b_pass", 32'(pass_b), 32'(e.pss));
                chk("b_mismatch_cnt", 32'(mm_b), 32'(e.mm));
                chk("b_first_mismatch", 32'(first_b), 32'(e.first));
                chk("b_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drain_a();
        for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q_a.size() != 0) begin
            fail_now("a_done_timeout");
            q_a.delete();
        end
    endtask

    task automatic drain_b();
        for (int i = 0; i < 200 && q_b.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q_b.size() != 0) begin
            fail_now("b_done_timeout");
            q_b.delete();
        end
    endtask

    task automatic sweep_a(input int m, input logic [7:0] et, input logic ep,
                           input logic [3:0] em, input logic [2:0] ef, input bit chk_vec);
        exp_t e;
        mode = m;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        e.tbl = et; e.pss = ep; e.mm = em; e.first = ef; e.cyc = cyc + 16;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        if (chk_vec) begin
            chk("a_busy_after_start", 32'(busy_a), 32'd1);
            for (int j = 0; j < 16; j++) begin
                chk("a_dut_in_step", 32'(dut_in_a), 32'(j / 2));
                @(negedge clk);
            end
        end
        drain_a();
    endtask

    task automatic wait_done_a();
        int i;
        i = 0;
        @(negedge clk);
        while (!done_a && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!done_a) fail_now("a_wait_done_timeout");
    endtask

    initial begin
        exp_t e;
        checks  = 0;
        errors  = 0;
        mode    = 0;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dut_in", 32'(dut_in_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_table", 32'(tbl_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_mismatch_cnt", 32'(mm_a), 32'd0);
        chk("rst_first_mismatch", 32'(first_a), 32'd0);
        reset = 1'b0;

        // Reference function, then a | b, then stuck-at-0.
        sweep_a(0, 8'hF4, 1'b1, 4'd0, 3'd0, 1'b1);
        sweep_a(1, 8'hFC, 1'b0, 4'd1, 3'd3, 1'b0);
        sweep_a(2, 8'h00, 1'b0, 4'd5, 3'd2, 1'b0);

        // Longer settle with a two-cycle-late function output.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        e.tbl = 8'hF4; e.pss = 1'b1; e.mm = 4'd0; e.first = 3'd0; e.cyc = cyc + 32;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        for (int j = 0; j < 32; j++) begin
            chk("b_dut_in_step", 32'(dut_in_b), 32'(j / 4));
            @(negedge clk);
        end
        drain_b();

        // Reset in the middle of a sweep.
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 40 && dut_in_a != 3'd4; i++) @(negedge clk);
        chk("mid_reset_reached_idx4", 32'(dut_in_a), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_dut_in", 32'(dut_in_a), 32'd0);
        chk("mid_reset_busy", 32'(busy_a), 32'd0);
        chk("mid_reset_done", 32'(done_a), 32'd0);
        chk("mid_reset_table", 32'(tbl_a), 32'd0);
        chk("mid_reset_mismatch_cnt", 32'(mm_a), 32'd0);
        chk("mid_reset_first", 32'(first_a), 32'd0);
        chk("mid_reset_pass", 32'(pass_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        sweep_a(0, 8'hF4, 1'b1, 4'd0, 3'd0, 1'b1);

        // Start held high: back-to-back sweeps.
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e.tbl = 8'hF4; e.pss = 1'b1; e.mm = 4'd0; e.first = 3'd0;
            e.cyc = cyc + 16 + 18 * k;
            q_a.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            wait_done_a();
            @(negedge clk);
            chk("held_busy_gap", 32'(busy_a), 32'd0);
            @(negedge clk);
            chk("held_busy_rise", 32'(busy_a), 32'd1);
        end
        start_a = 1'b0;
        drain_a();
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
